// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the boot loader.
// slave is the loader side; master is the byte source / memory side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: count + big-endian bytes -> 32-bit imem writes, then releases cpu_rst.
// 4 accept cycles + 1 write cycle per word; in_ready drops in WRITE/DONE/ERR so the sender holds its byte.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // One extra bit so any 16-bit count compares cleanly against DEPTH.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [15:0] idx_q,   idx_d;
    logic [1:0]  byte_q,  byte_d;
    logic [23:0] word_q,  word_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic [15:0] cnt_full;
    logic        last_word;

    assign accept    = bus.in_valid && bus.in_ready;
    assign cnt_full  = {cnt_q[15:8], bus.in_data};
    assign last_word = (idx_q + 16'd1) == cnt_q;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CNT_HI: begin
                if (accept) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (cnt_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, cnt_full} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_DATA;
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_CNT_HI;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        bus.in_ready = rst && ((state_q == S_CNT_HI) ||
                               (state_q == S_CNT_LO) ||
                               (state_q == S_DATA));
        bus.imem_we  = (state_q == S_WRITE);
        done         = (state_q == S_DONE);
        cpu_rst      = (state_q == S_DONE);
        err          = (state_q == S_ERR);
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // ---------------------------------------------------------------
    // Datapath: count, word index, byte packing, write address/data
    // ---------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_CNT_HI: begin
                if (accept) cnt_d[15:8] = bus.in_data;
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = bus.in_data;
                    idx_d      = 16'd0;
                    byte_d     = 2'd0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_d = 2'(byte_q + 2'd1);
                    word_d = {word_q[15:0], bus.in_data};
                    // The 4th byte goes straight into the write register, so
                    // only three bytes ever need holding.
                    if (byte_q == 2'd3) begin
                        addr_d  = {14'd0, idx_q, 2'b00};
                        wdata_d = {word_q, bus.in_data};
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 16'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 16'd0;
            idx_q   <= 16'd0;
            byte_q  <= 2'd0;
            word_q  <= 24'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the nominal load plus
// hand sequences for empty/oversize/boundary/gap/reset-mid-load streams.
module tb_imem_loader;

    logic clk;
    logic rst;
    logic cpu_rst;
    logic done;
    logic err;

    imem_loader_if bus();

    imem_loader #(.DEPTH(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] exp_q[$];

    // Memory-side view: a write happens on the edge that ends a we cycle.
    always @(posedge clk) begin
        if (bus.imem_we) begin
            wq_addr.push_back(bus.imem_addr);
            wq_data.push_back(bus.imem_wdata);
            n_checks++;
            if (bus.in_ready) begin
                n_fail++;
                $display("FAIL ready_in_write: in_ready=1 while imem_we=1, want 0");
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".in_ready"},   {31'd0, bus.in_ready}, 32'd0);
        chk({nm, ".imem_we"},    {31'd0, bus.imem_we},  32'd0);
        chk({nm, ".imem_addr"},  bus.imem_addr,         32'd0);
        chk({nm, ".imem_wdata"}, bus.imem_wdata,        32'd0);
        chk({nm, ".cpu_rst"},    {31'd0, cpu_rst},      32'd0);
        chk({nm, ".done"},       {31'd0, done},         32'd0);
        chk({nm, ".err"},        {31'd0, err},          32'd0);
    endtask

    // Entered and left at a negedge; reset held two cycles.
    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wq_addr.delete();
        wq_data.delete();
    endtask

    // Offers a byte after 'gap' idle cycles and holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted in 200 cycles", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[k*8 +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end
    endtask

    task automatic wait_end(input string nm);
        int t;
        t = 0;
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.end_timeout: no done/err in 100 cycles", nm);
        end
    endtask

    task automatic chk_writes(input string nm);
        chk({nm, ".nwrites"}, wq_addr.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq_addr.size(); i++) begin
            chk($sformatf("%s.addr[%0d]", nm, i), wq_addr[i], 32'(i * 4));
            chk($sformatf("%s.data[%0d]", nm, i), wq_data[i], exp_q[i]);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        dn;
        logic        er;
    } vec_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dn;
        logic       er;
    } cnt_vec_t;

    vec_t     tab[19];
    cnt_vec_t ctab[4];
    logic [31:0] nom[3];

    initial begin
        nom[0] = 32'h2008_0005;
        nom[1] = 32'h2009_0007;
        nom[2] = 32'h0109_5020;

        // Nominal load, one record per cycle: inputs driven, outputs expected.
        tab[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[1]  = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[2]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[3]  = '{1'b1, 8'h08, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0};
        tab[6]  = '{1'b1, 8'h20, 1'b0, 1'b1, 32'h0, 32'h20080005, 1'b0, 1'b0};
        tab[7]  = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b0, 1'b0};
        tab[8]  = '{1'b1, 8'h09, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b0, 1'b0};
        tab[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b0, 1'b0};
        tab[10] = '{1'b1, 8'h07, 1'b1, 1'b0, 32'h0, 32'h20080005, 1'b0, 1'b0};
        tab[11] = '{1'b1, 8'h01, 1'b0, 1'b1, 32'h4, 32'h20090007, 1'b0, 1'b0};
        tab[12] = '{1'b1, 8'h01, 1'b1, 1'b0, 32'h4, 32'h20090007, 1'b0, 1'b0};
        tab[13] = '{1'b1, 8'h09, 1'b1, 1'b0, 32'h4, 32'h20090007, 1'b0, 1'b0};
        tab[14] = '{1'b1, 8'h50, 1'b1, 1'b0, 32'h4, 32'h20090007, 1'b0, 1'b0};
        tab[15] = '{1'b1, 8'h20, 1'b1, 1'b0, 32'h4, 32'h20090007, 1'b0, 1'b0};
        tab[16] = '{1'b1, 8'hEE, 1'b0, 1'b1, 32'h8, 32'h01095020, 1'b0, 1'b0};
        tab[17] = '{1'b1, 8'hEE, 1'b0, 1'b0, 32'h8, 32'h01095020, 1'b1, 1'b0};
        tab[18] = '{1'b1, 8'hEE, 1'b0, 1'b0, 32'h8, 32'h01095020, 1'b1, 1'b0};

        // Count-only streams: empty, just over DEPTH, high byte matters, max.
        ctab[0] = '{8'h00, 8'h00, 1'b1, 1'b0};
        ctab[1] = '{8'h00, 8'h41, 1'b0, 1'b1};
        ctab[2] = '{8'h01, 8'h40, 1'b0, 1'b1};
        ctab[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1};

        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAB;
        @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b1;
        wq_addr.delete();
        wq_data.delete();

        // ---- nominal, cycle by cycle ----
        for (int i = 0; i < 19; i++) begin
            bus.in_valid = tab[i].v;
            bus.in_data  = tab[i].d;
            #1;
            chk($sformatf("nom[%0d].in_ready", i), {31'd0, bus.in_ready}, {31'd0, tab[i].rdy});
            chk($sformatf("nom[%0d].imem_we", i),  {31'd0, bus.imem_we},  {31'd0, tab[i].we});
            chk($sformatf("nom[%0d].addr", i),     bus.imem_addr,         tab[i].addr);
            chk($sformatf("nom[%0d].wdata", i),    bus.imem_wdata,        tab[i].wdata);
            chk($sformatf("nom[%0d].done", i),     {31'd0, done},         {31'd0, tab[i].dn});
            chk($sformatf("nom[%0d].cpu_rst", i),  {31'd0, cpu_rst},      {31'd0, tab[i].dn});
            chk($sformatf("nom[%0d].err", i),      {31'd0, err},          {31'd0, tab[i].er});
            @(negedge clk);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(nom[i]);
        chk_writes("nom");

        // ---- count-only streams ----
        for (int i = 0; i < 4; i++) begin
            logic ever_ready;
            do_reset();
            exp_q.delete();
            send_byte(ctab[i].hi, 0);
            send_byte(ctab[i].lo, 0);
            #1;
            chk($sformatf("cnt[%0d].done", i),    {31'd0, done},    {31'd0, ctab[i].dn});
            chk($sformatf("cnt[%0d].cpu_rst", i), {31'd0, cpu_rst}, {31'd0, ctab[i].dn});
            chk($sformatf("cnt[%0d].err", i),     {31'd0, err},     {31'd0, ctab[i].er});
            ever_ready   = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h55;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                #1;
                if (bus.in_ready) ever_ready = 1'b1;
            end
            bus.in_valid = 1'b0;
            chk($sformatf("cnt[%0d].ready_stuck_low", i), {31'd0, ever_ready}, 32'd0);
            chk($sformatf("cnt[%0d].done_held", i), {31'd0, done}, {31'd0, ctab[i].dn});
            chk($sformatf("cnt[%0d].err_held", i),  {31'd0, err},  {31'd0, ctab[i].er});
            chk_writes($sformatf("cnt[%0d]", i));
            @(negedge clk);
        end

        // ---- boundary N == DEPTH ----
        do_reset();
        exp_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(32'hA500_0000 | 32'(k));
            send_word(32'hA500_0000 | 32'(k), 0);
        end
        wait_end("bnd");
        #1;
        chk_writes("bnd");
        if (wq_addr.size() == 64) begin
            chk("bnd.last_addr", wq_addr[63], 32'h0000_00FC);
            chk("bnd.last_data", wq_data[63], 32'hA500_003F);
        end
        chk("bnd.done", {31'd0, done}, 32'd1);
        chk("bnd.err",  {31'd0, err},  32'd0);

        // ---- nominal with random valid gaps ----
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(nom[i]);
        send_byte(8'h00, int'($urandom_range(3, 0)));
        send_byte(8'h03, int'($urandom_range(3, 0)));
        for (int i = 0; i < 3; i++) send_word(nom[i], 3);
        wait_end("gap");
        #1;
        chk_writes("gap");
        chk("gap.done", {31'd0, done}, 32'd1);
        chk("gap.err",  {31'd0, err},  32'd0);

        // ---- reset after the 6th accepted byte ----
        do_reset();
        exp_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        #1;
        chk_reset_vals("midrst_hold");
        chk("midrst.nwrites", wq_addr.size(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(nom[i]);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) send_word(nom[i], 0);
        wait_end("midrst");
        #1;
        chk_writes("midrst");
        chk("midrst.done",    {31'd0, done},    32'd1);
        chk("midrst.cpu_rst", {31'd0, cpu_rst}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle datapath. It accepts a program as a byte stream over a valid/ready handshake, packs big-endian bytes into 32-bit words and writes them to instruction memory at consecutive word-aligned byte addresses starting at 0. It holds the processor in reset until the whole image is written, then releases it so fetch starts at PC 0.

## Interface

Parameters:
- DEPTH, 64, instruction memory size in 32-bit words; the legal word count is 0..DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  program byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  byte address of the write; always a multiple of 4.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  active-low reset for the datapath; low until load completes.
- done  out  1  load completed successfully.
- err  out  1  word count exceeded DEPTH.

## Operation

- Stream format: a 16-bit word count N (high byte first), then N×4 data bytes, with each word sent most-significant byte first.
- A byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- States and transitions:
  - CNT_HI: accept byte into N[15:8] -> CNT_LO.
  - CNT_LO: accept byte into N[7:0]. Then:
    - N==0 -> DONE, with no writes.
    - N>DEPTH -> ERR.
    - otherwise -> DATA, with word index 0 and byte index 0.
  - DATA: shift each accepted byte into the word register. On the 4th byte -> WRITE.
  - WRITE: for one cycle, imem_we=1, imem_addr=index×4, imem_wdata=assembled word. Then increment the index.
    - If index+1==N -> DONE.
    - else -> DATA.
  - DONE: terminal. done=1, cpu_rst=1.
  - ERR: terminal. err=1, cpu_rst stays 0.
  - Only rst leaves DONE or ERR.
- in_ready = rst && state ∈ {CNT_HI, CNT_LO, DATA}. It is combinational from state and rst.
- in_ready is low in WRITE, DONE and ERR. A byte offered there stays pending, and the sender must hold it.
- imem_addr and imem_wdata hold their last values outside WRITE. Only imem_we qualifies them.
- Bytes beyond the declared image are never accepted, because in_ready stays low in DONE and ERR.

## Timing

- Reset values while rst=0:
  - state CNT_HI, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=0, done=0, err=0.
  - N, word index and byte index all 0.
- The first byte can be accepted on the first rising edge after rst deasserts.
- Each word needs 4 accept cycles plus 1 WRITE cycle. With in_valid held high, a load of N words takes 2+5N cycles from the first accept to entering DONE.
- done and cpu_rst rise on the edge that enters DONE: the edge ending the last WRITE cycle, or the second count byte when N==0.
- err rises on the edge that accepts the second count byte.
- Reset mid-load:
  - Immediate return to the reset values, with the partially assembled word discarded.
  - Words already written stay in memory; the loader never clears memory.
  - A fresh stream must restart from the count bytes.
- Gaps in in_valid stall the state machine only. Byte order and addresses are unaffected.
- N==DEPTH is legal: the last write goes to address (DEPTH−1)×4.
- Counters are 16-bit, so N up to 0xFFFF compares correctly against DEPTH without overflow.

## Test plan

- Nominal load, in_valid always high, DEPTH=64.
  - Stimulus: stream 00 03, 20 08 00 05, 20 09 00 07, 01 09 50 20.
  - Required: exactly three imem_we pulses, (0x0, 0x20080005), (0x4, 0x20090007), (0x8, 0x01095020). done and cpu_rst rise 17 cycles after the first accept. err stays 0.
- Empty image.
  - Stimulus: stream 00 00.
  - Required: no imem_we. done=1 and cpu_rst=1 on the edge after the second byte. in_ready=0 afterwards.
- Oversize image.
  - Stimulus: stream 00 41 (N=65).
  - Required: err=1, cpu_rst stays 0, no writes, in_ready stuck low until rst.
- Boundary image.
  - Stimulus: stream N=64 (00 40) with word k = 0xA5000000|k.
  - Required: 64 writes, the last at address 0xFC with data 0xA500003F. Then done.
- Backpressure and gaps.
  - Stimulus: nominal stream with random in_valid gaps, and in_valid held high through each WRITE cycle.
  - Required: in_ready=0 in WRITE, no byte lost or duplicated, and write data/addresses identical to the nominal case.
- Reset mid-load.
  - Stimulus: assert rst after the 6th accepted byte, then release it and send the full nominal stream.
  - Required: all outputs return to reset values immediately while rst=0. The stale partial word is never written. Final writes match the nominal case.
